uart_tx_serializer: RTL and testbench

- UART transmitter that sits directly downstream of the clock-reduction stage. It consumes a baud-rate timebase and produces the serial TX line.
- Runs in a single clock domain: an internal per-bit cycle counter replaces ripple-derived clocks, so no generated clock drives any flop.
- Accepts one parallel byte per valid/ready handshake and emits a frame of start, DATA_BITS data bits LSB-first, optional parity, and STOP_BITS stop bits.

---
 rtl/uart_tx_serializer.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional even parity,
// STOP_BITS stop bits. Define UART_TX_PARITY_EN to compile in the parity bit.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [DATA_BITS-1:0] shift_reg, shift_d;
  logic                 tx_d;
  logic                 done_d;
  logic                 bit_end;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  assign bit_end  = (bit_cnt == CNT_LAST);
  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = ~tx_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    idx_d     = idx;
    shift_d   = shift_reg;
    done_d    = 1'b0;
    tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state != S_IDLE) begin
      bit_cnt_d = bit_end ? '0 : bit_cnt + CNT_W'(1);
    end

    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          idx_d   = '0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_reg >> 1;
          if (idx == DATA_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (idx == STOP_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The line level is decoded from the *next* state so tx itself can be a flop.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the shift register is reset along with the control flops so the datapath
  // starts from a known value after an abandoned frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      idx       <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      idx       <= idx_d;
      shift_reg <= shift_d;
      tx        <= tx_d;
      tx_done   <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: directed and random frames checked
// cycle by cycle against a bit-list model of the frame. Honours UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

  localparam int CLKS_PER_BIT = 16;
  localparam int DATA_BITS    = 8;
  localparam int STOP_BITS    = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS     = 1;
`else
  localparam int PAR_BITS     = 0;
`endif
  localparam int FRAME_BITS   = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int FRAME_CYC    = FRAME_BITS * CLKS_PER_BIT;
  localparam int WAIT_BUDGET  = 2 * FRAME_CYC;

  logic                 clk;
  logic                 reset;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  int tests = 0;
  int fails = 0;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS),
    .STOP_BITS   (STOP_BITS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle line for n cycles: mark level, ready, no done pulse.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_ready", tx_ready, 1'b1);
      check("idle_done", tx_done, 1'b0);
    end
  endtask

  // Offer word d, then follow the whole frame against the model's bit list.
  // Called and returns just after a falling edge; returns in the tx_done cycle.
  task automatic do_frame(input logic [DATA_BITS-1:0] d, input bit keep_valid,
                          input logic [DATA_BITS-1:0] d_after, input bit expect_immediate,
                          input int pulse_at);
    bit bits[$];
    int w;
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    for (int i = 0; i < STOP_BITS; i++) bits.push_back(1'b1);

    tx_data  = d;
    tx_valid = 1'b1;
    w = 0;
    while (tx_ready !== 1'b1 && w < WAIT_BUDGET) begin
      @(negedge clk);
      w++;
    end
    check("accept_timeout", (w < WAIT_BUDGET), 1'b1);
    if (expect_immediate) check("b2b_wait", w, 0);

    @(posedge clk);
    #1;
    tx_data  = d_after;
    tx_valid = keep_valid;

    for (int n = 1; n <= FRAME_CYC; n++) begin
      @(negedge clk);
      if (n == pulse_at) begin
        tx_valid = 1'b1;
        tx_data  = '1;
      end else if (n == pulse_at + 1) begin
        tx_valid = 1'b0;
        tx_data  = d_after;
      end
      check("frame_tx", tx, bits[(n - 1) / CLKS_PER_BIT]);
      check("frame_done_early", tx_done, 1'b0);
      if ((n - 1) % CLKS_PER_BIT == CLKS_PER_BIT / 2) begin
        check("frame_busy", tx_busy, 1'b1);
        check("frame_not_ready", tx_ready, 1'b0);
      end
    end

    @(negedge clk);
    check("done_pulse", tx_done, 1'b1);
    check("done_ready", tx_ready, 1'b1);
    check("done_busy", tx_busy, 1'b0);
    check("done_tx_idle", tx, 1'b1);
  endtask

  initial begin
    logic [DATA_BITS-1:0] cur;
    logic [DATA_BITS-1:0] nxt;
    bit keep;
    bit prev_keep;

    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;

    repeat (5) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    reset = 1'b1;
    idle_cycles(100);

    do_frame(8'hA5, 1'b0, 8'h00, 1'b0, -1);
    idle_cycles(3);
    do_frame(8'h07, 1'b0, 8'h00, 1'b0, -1);
    idle_cycles(2);

    // Back-to-back: valid held high; data changed right after acceptance.
    do_frame(8'h55, 1'b1, 8'hAA, 1'b0, -1);
    do_frame(8'hAA, 1'b0, 8'h00, 1'b1, -1);
    idle_cycles(2);

    // Busy rejection: a one-cycle 0xFF offer in the middle of data bit 2.
    do_frame(8'h3C, 1'b0, 8'h00, 1'b0, 3 * CLKS_PER_BIT + CLKS_PER_BIT / 2);
    idle_cycles(40);

    // Reset in the middle of data bit 3 of 0x37 (bit 3 is a zero on the line).
    tx_data  = 8'h37;
    tx_valid = 1'b1;
    check("mid_pre_ready", tx_ready, 1'b1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (4 * CLKS_PER_BIT + CLKS_PER_BIT / 2 + 1) @(negedge clk);
    check("mid_bit3", tx, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_ready", tx_ready, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_done", tx_done, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_cycles(FRAME_CYC + 20);
    do_frame(8'h81, 1'b0, 8'h00, 1'b0, -1);
    idle_cycles(2);

    // Random words, randomly back-to-back or separated by short idle gaps.
    prev_keep = 1'b0;
    nxt = DATA_BITS'($urandom);
    for (int k = 0; k < 8; k++) begin
      cur  = nxt;
      nxt  = DATA_BITS'($urandom);
      keep = bit'($urandom_range(0, 1));
      do_frame(cur, keep, nxt, prev_keep, -1);
      if (!keep) idle_cycles($urandom_range(1, 5));
      prev_keep = keep;
    end
    if (prev_keep) begin
      do_frame(nxt, 1'b0, 8'h00, 1'b1, -1);
      idle_cycles(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
